// File: rtl/cdb_arbiter_pkg.sv
// Shared core types for the CDB arbiter: the rv32i_types result-packet layout plus
// arbiter-local constants and pointer arithmetic.
package rv32i_types;
  localparam int ROB_IDX_W  = 5;
  localparam int PREG_IDX_W = 6;
  localparam int AREG_IDX_W = 5;
  localparam int XLEN       = 32;

  typedef logic [ROB_IDX_W-1:0]  rob_idx_t;
  typedef logic [PREG_IDX_W-1:0] preg_idx_t;
  typedef logic [AREG_IDX_W-1:0] areg_idx_t;

  typedef struct packed {
    rob_idx_t         rob_idx;
    preg_idx_t        pd;
    areg_idx_t        rd;
    logic [XLEN-1:0]  data;
  } cdb_t;
endpackage

package cdb_arbiter_pkg;
  typedef rv32i_types::cdb_t cdb_t;

  localparam int MIN_FU = 2;
  localparam int MAX_FU = 8;

  // Explicit wrap keeps the pointer legal when NUM_FU is not a power of two.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit side of the common data bus: requests/packets in, grants and the
// registered broadcast out.
interface cdb_arbiter_if #(parameter int NUM_FU = 4);
  import cdb_arbiter_pkg::*;

  logic [NUM_FU-1:0]  fu_req;
  cdb_t [NUM_FU-1:0]  fu_pkt;
  logic               flush;
  logic [NUM_FU-1:0]  fu_gnt;
  logic               cdb_valid;
  cdb_t               cdb_out;

  modport master (
    output fu_req, fu_pkt, flush,
    input  fu_gnt, cdb_valid, cdb_out
  );

  modport slave (
    input  fu_req, fu_pkt, flush,
    output fu_gnt, cdb_valid, cdb_out
  );
endinterface

// File: rtl/cdb_arbiter_rr_select.sv
// Purely combinational round-robin search: first requester at or after ptr, upward
// modulo NUM_FU, returned both one-hot and as an index.
module rr_select #(
  parameter int NUM_FU = 4,
  parameter int PTR_W  = $clog2(NUM_FU)
) (
  input  logic [NUM_FU-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_FU-1:0] gnt,
  output logic [PTR_W-1:0]  gnt_idx,
  output logic              gnt_valid
);

  localparam logic [PTR_W:0] NUM_FU_W = (PTR_W+1)'(NUM_FU);

  logic [PTR_W:0]   sum;
  logic [PTR_W:0]   idx_n;
  logic [PTR_W-1:0] cur;

  // One spare bit on the sum so ptr+k never overflows before the modulo fold.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    sum       = '0;
    idx_n     = '0;
    cur       = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      sum   = {1'b0, ptr} + (PTR_W+1)'(k);
      idx_n = (sum >= NUM_FU_W) ? (sum - NUM_FU_W) : sum;
      cur   = idx_n[PTR_W-1:0];
      if (!gnt_valid && req[cur]) begin
        gnt_valid = 1'b1;
        gnt[cur]  = 1'b1;
        gnt_idx   = cur;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin grant among NUM_FU (2..8) requesters, granted
// packet broadcast exactly one cycle later; flush kills the next broadcast only.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = 4
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_FU);

  logic [PTR_W-1:0]  rr_ptr;
  logic [NUM_FU-1:0] arb_req;
  logic [NUM_FU-1:0] sel_gnt;
  logic [PTR_W-1:0]  sel_idx;
  logic              sel_valid;
  logic              cdb_valid_q;
  cdb_t              cdb_out_q;

  // Reset and flush both mask requests, so neither can produce a grant or move rr_ptr.
  assign arb_req = (rst || bus.flush) ? '0 : bus.fu_req;

  rr_select #(
    .NUM_FU (NUM_FU),
    .PTR_W  (PTR_W)
  ) u_rr_select (
    .req       (arb_req),
    .ptr       (rr_ptr),
    .gnt       (sel_gnt),
    .gnt_idx   (sel_idx),
    .gnt_valid (sel_valid)
  );

  assign bus.fu_gnt = sel_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      cdb_valid_q <= 1'b0;
      cdb_out_q   <= '0;
    end else begin
      cdb_valid_q <= sel_valid;
      if (sel_valid) begin
        cdb_out_q <= bus.fu_pkt[sel_idx];
        rr_ptr    <= PTR_W'(wrap_inc(int'(sel_idx), NUM_FU));
      end
    end
  end

  // Outputs read as zero for the whole reset window, including its first cycle.
  assign bus.cdb_valid = cdb_valid_q & ~rst;
  assign bus.cdb_out   = rst ? '0 : cdb_out_q;

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(bus.fu_gnt));
  a_gnt_in_req  : assert property (@(posedge clk) disable iff (rst) (bus.fu_gnt & ~bus.fu_req) == '0);

endmodule
